req_pend_tracker: RTL and testbench

REQ_PEND_TRACKER -- requirements
Module: req_pend_tracker

---
 rtl/pim_req_pkg.sv | 8 +
 rtl/req_pend_tracker_if.sv | 28 ++
 rtl/req_age_ctr.sv | 34 +++
 rtl/req_pend_tracker.sv | 111 +++++++++++
 tb/tb_req_pend_tracker.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/pim_req_pkg.sv
// Shared request-slot definitions for the pending tracker and the downstream priority encoder.
package pim_req_pkg;
  localparam int WIDTH_DEF      = 16;
  localparam int STARVE_LIM_DEF = 15;
  localparam int IW_DEF         = $clog2(WIDTH_DEF);

  typedef logic [IW_DEF-1:0] slot_idx_t;
endpackage

// File: rtl/req_pend_tracker_if.sv
// Request/service handshake and pending-vector bundle between requesters and the tracker.
interface req_pend_tracker_if
  import pim_req_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IW    = $clog2(WIDTH)
);
  logic             req_valid;
  logic [IW-1:0]    req_idx;
  logic             req_ready;
  logic             svc_valid;
  logic [IW-1:0]    svc_idx;
  logic [WIDTH-1:0] pend_vec;
  logic             pend_any;
  logic [IW:0]      pend_cnt;
  logic             svc_err;
  logic             starve_act;

  modport master (
    output req_valid, req_idx, svc_valid, svc_idx,
    input  req_ready, pend_vec, pend_any, pend_cnt, svc_err, starve_act
  );

  modport slave (
    input  req_valid, req_idx, svc_valid, svc_idx,
    output req_ready, pend_vec, pend_any, pend_cnt, svc_err, starve_act
  );
endinterface

// File: rtl/req_age_ctr.sv
// Single-slot saturating age counter; flags the slot as starved once its age reaches STARVE_LIM.
module req_age_ctr
  import pim_req_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int AW         = $clog2(STARVE_LIM + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic pend,
  input  logic svc,
  output logic starve_nxt
);
  logic [AW-1:0] age_q;
  logic [AW-1:0] age_nxt;

  always_comb begin
    age_nxt = age_q;
    if (!pend || svc)
      age_nxt = '0;
    else if (age_q != AW'(STARVE_LIM))
      age_nxt = age_q + AW'(1);
  end

  // Look-ahead flag so the tracker can register the override in the same edge as the age.
  assign starve_nxt = (age_nxt == AW'(STARVE_LIM));

  always_ff @(posedge clk) begin
    if (rst)
      age_q <= '0;
    else
      age_q <= age_nxt;
  end
endmodule

// File: rtl/req_pend_tracker.sv
// Pending-request tracker feeding a priority encoder; optional starvation override
// compiled in with macro REQ_PEND_STARVE_EN.
module req_pend_tracker
  import pim_req_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int IW         = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst,
  req_pend_tracker_if.slave bus
);
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] pend_nxt;
  logic [WIDTH-1:0] vec_nxt;
  logic [WIDTH-1:0] vec_q;
  logic [IW:0]      cnt_q;
  logic             any_q;
  logic             err_q;
  logic             accept;
  logic             svc_hit;
  logic             svc_miss;

  function automatic logic [IW:0] popcnt(input logic [WIDTH-1:0] v);
    logic [IW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + {{IW{1'b0}}, v[i]};
    return c;
  endfunction

  // A slot being serviced this cycle can be re-requested in the same cycle.
  assign bus.req_ready = !pend_q[bus.req_idx] ||
                         (bus.svc_valid && (bus.svc_idx == bus.req_idx));
  assign accept   = bus.req_valid && bus.req_ready;
  assign svc_hit  = bus.svc_valid &&  pend_q[bus.svc_idx];
  assign svc_miss = bus.svc_valid && !pend_q[bus.svc_idx];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept)  set_vec[bus.req_idx] = 1'b1;
    if (svc_hit) clr_vec[bus.svc_idx] = 1'b1;
    pend_nxt = (pend_q & ~clr_vec) | set_vec;
  end

`ifdef REQ_PEND_STARVE_EN
  logic [WIDTH-1:0] starve_vec;
  logic             starve_nxt;
  logic             starve_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_age
    req_age_ctr #(.STARVE_LIM(STARVE_LIM)) u_age (
      .clk        (clk),
      .rst        (rst),
      .pend       (pend_q[i]),
      .svc        (clr_vec[i]),
      .starve_nxt (starve_vec[i])
    );
  end

  // Highest-indexed starved slot wins the one-hot override.
  always_comb begin
    vec_nxt    = pend_nxt;
    starve_nxt = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (starve_vec[i]) begin
        vec_nxt    = '0;
        vec_nxt[i] = 1'b1;
        starve_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      starve_q <= 1'b0;
    else
      starve_q <= starve_nxt;
  end

  assign bus.starve_act = starve_q;
`else
  assign vec_nxt        = pend_nxt;
  assign bus.starve_act = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      vec_q  <= '0;
      cnt_q  <= '0;
      any_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      vec_q  <= vec_nxt;
      cnt_q  <= popcnt(pend_nxt);
      any_q  <= |pend_nxt;
      err_q  <= err_q | svc_miss;
    end
  end

  assign bus.pend_vec = vec_q;
  assign bus.pend_cnt = cnt_q;
  assign bus.pend_any = any_q;
  assign bus.svc_err  = err_q;
endmodule

// File: tb/tb_req_pend_tracker.sv
// Directed bench for req_pend_tracker; expectations follow REQ_PEND_STARVE_EN when defined.
module tb_req_pend_tracker;
  import pim_req_pkg::*;

`ifdef REQ_PEND_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  req_pend_tracker_if #(.WIDTH(16)) bus ();

  req_pend_tracker #(.WIDTH(16), .STARVE_LIM(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_idx   = '0;
    bus.svc_valid = 1'b0;
    bus.svc_idx   = '0;
  endtask

  task automatic drive(input logic rv, input int ri, input logic sv, input int si);
    bus.req_valid = rv;
    bus.req_idx   = 4'(ri);
    bus.svc_valid = sv;
    bus.svc_idx   = 4'(si);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] vec, input int cnt,
                         input logic any, input logic err, input logic stv);
    chk({tag, "_vec"},    32'(bus.pend_vec),   32'(vec));
    chk({tag, "_cnt"},    32'(bus.pend_cnt),   32'(cnt));
    chk({tag, "_any"},    32'(bus.pend_any),   32'(any));
    chk({tag, "_err"},    32'(bus.svc_err),    32'(err));
    chk({tag, "_starve"}, 32'(bus.starve_act), 32'(stv));
  endtask

  initial begin
    // Reset with busy inputs: they must be ignored.
    rst = 1'b1;
    drive(1'b1, 2, 1'b1, 6);
    tick();
    tick();
    chk_all("reset", 16'h0000, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    tick();
    chk_all("post_reset", 16'h0000, 0, 1'b0, 1'b0, 1'b0);

    // Single request, then its service.
    drive(1'b1, 3, 1'b0, 0);
    tick();
    idle();
    chk_all("req3", 16'h0008, 1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 3);
    tick();
    idle();
    chk_all("svc3", 16'h0000, 0, 1'b0, 1'b0, 1'b0);

    // Re-offer of a pending slot, without and with same-cycle service.
    drive(1'b1, 5, 1'b0, 0);
    tick();
    drive(1'b1, 5, 1'b0, 0);
    #1;
    chk("ready_busy", 32'(bus.req_ready), 32'd0);
    tick();
    chk_all("reoffer5", 16'h0020, 1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b1, 5);
    #1;
    chk("ready_svc", 32'(bus.req_ready), 32'd1);
    tick();
    idle();
    chk_all("setwins5", 16'h0020, 1, 1'b1, 1'b0, 1'b0);

    // Accept and service of different slots in one edge.
    drive(1'b1, 9, 1'b1, 5);
    tick();
    idle();
    chk_all("swap9_5", 16'h0200, 1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 9);
    tick();
    idle();
    chk_all("svc9", 16'h0000, 0, 1'b0, 1'b0, 1'b0);

    // Service of an empty slot: sticky error, no state change.
    drive(1'b0, 0, 1'b1, 7);
    tick();
    idle();
    chk_all("svc_empty", 16'h0000, 0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("err_sticky", 32'(bus.svc_err), 32'd1);

    // Fill all slots, then reset mid-sequence.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i, 1'b0, 0);
      tick();
      if (i == 7) chk_all("fill8", 16'h00FF, 8, 1'b1, 1'b1, 1'b0);
    end
    idle();
    // Slot 0 has been waiting 15 edges by now, so the override engages when enabled.
    chk_all("fill16", STARVE ? 16'h0001 : 16'hFFFF, 16, 1'b1, 1'b1, STARVE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 16'h0000, 0, 1'b0, 1'b0, 1'b0);

    // Starvation scenario: slot 12 left waiting while slot 0 is serviced and re-requested.
    drive(1'b1, 12, 1'b0, 0);
    tick();
    drive(1'b1, 0, 1'b0, 0);
    tick();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 0, 1'b1, 0);
      tick();
    end
    chk_all("age14", 16'h1001, 2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 0, 1'b1, 0);
    tick();
    chk_all("age15", STARVE ? 16'h1000 : 16'h1001, 2, 1'b1, 1'b0, STARVE);
    drive(1'b0, 0, 1'b1, 12);
    tick();
    idle();
    chk_all("svc12", 16'h0001, 1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
